// File: rtl/sr_flag_sched.sv
// ----------------------------------------------------------------------------
// sr_flag_sched
//   Round-robin scheduler in front of a bank of set/reset flags. Each cycle,
//   one eligible requester is granted. Its op (nop/set/clear/toggle) is
//   applied to the flag it addresses at that same edge. A requester whose
//   grant is currently high is not eligible, so a request held through its
//   grant cycle is never granted twice back-to-back.
//
// Parameters
//   NREQ  : number of requesters (2..8)
//   NFLAG : number of flags in the bank (power of two, 2..32)
//   IW    : flag index width (log2(NFLAG))
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   req      in   [NREQ]      per-requester request, held until granted
//   op       in   [2*NREQ]    per-requester op: 00 nop, 01 set, 10 clear, 11 toggle
//   idx      in   [IW*NREQ]   per-requester target flag index
//   gnt      out  [NREQ]      registered one-hot grant pulse
//   q        out  [NFLAG]     flag bank state
//   conflict out  1           registered set/clear collision pulse
//
// Build option
//   SR_FLAG_SCHED_CONFLICT_EN : when defined, compiles in collision detection.
//   conflict pulses one cycle after an edge where two eligible requesters hit
//   the same index, one with set and the other with clear. When undefined,
//   conflict is tied to 0.
// ----------------------------------------------------------------------------
module sr_flag_sched #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IW    = $clog2(NFLAG)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [2*NREQ-1:0]  op,
  input  logic [IW*NREQ-1:0] idx,
  output logic [NREQ-1:0]    gnt,
  output logic [NFLAG-1:0]   q,
  output logic               conflict
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TGL = 2'b11;

  logic [PW-1:0]    r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [NFLAG-1:0] r_q;

  logic [NREQ-1:0]  w_elig;
  logic             w_any;
  logic [PW-1:0]    w_win;
  logic [NREQ-1:0]  w_gnt_nxt;
  logic [1:0]       w_op;
  logic [IW-1:0]    w_idx;

  // Modulo-NREQ add, used for the round-robin scan and pointer advance.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Apply one op to the bank. An index that matches no flag leaves the bank
  // untouched, which covers idx >= NFLAG when IW is wider than needed.
  function automatic logic [NFLAG-1:0] apply_op(input logic [NFLAG-1:0] bank,
                                                input logic [1:0]       o,
                                                input logic [IW-1:0]    ix);
    logic [NFLAG-1:0] b;
    b = bank;
    for (int f = 0; f < NFLAG; f++) begin
      if (int'(ix) == f) begin
        case (o)
          OP_SET:  b[f] = 1'b1;
          OP_CLR:  b[f] = 1'b0;
          OP_TGL:  b[f] = ~b[f];
          OP_NOP:  b[f] = b[f];
          default: b[f] = b[f];
        endcase
      end
    end
    return b;
  endfunction

  assign w_elig = req & ~r_gnt;

  // Scan from the pointer upward, wrapping; the first eligible requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && w_elig[wrap_add(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = wrap_add(r_ptr, k);
      end
    end
  end

  // Winner's op/idx and next one-hot grant.
  always_comb begin
    w_op      = OP_NOP;
    w_idx     = '0;
    w_gnt_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_op         = op[2*i +: 2];
        w_idx        = idx[IW*i +: IW];
        w_gnt_nxt[i] = w_any;
      end
    end
  end

  // Arbitration / flag update stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_gnt <= '0;
      r_q   <= '0;
    end else begin
      r_gnt <= w_gnt_nxt;
      if (w_any) begin
        r_ptr <= wrap_add(w_win, 1);
        r_q   <= apply_op(r_q, w_op, w_idx);
      end
    end
  end

  assign gnt = r_gnt;
  assign q   = r_q;

`ifdef SR_FLAG_SCHED_CONFLICT_EN
  logic r_conflict;
  logic w_conflict;

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (w_elig[i] && w_elig[j] &&
            (idx[IW*i +: IW] == idx[IW*j +: IW]) &&
            (((op[2*i +: 2] == OP_SET) && (op[2*j +: 2] == OP_CLR)) ||
             ((op[2*i +: 2] == OP_CLR) && (op[2*j +: 2] == OP_SET)))) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Collision flag stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_conflict <= 1'b0;
    else      r_conflict <= w_conflict;
  end

  assign conflict = r_conflict;
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_sr_flag_sched.sv
module tb_sr_flag_sched;
  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IW    = 3;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] SET = 2'b01;
  localparam logic [1:0] CLR = 2'b10;
  localparam logic [1:0] TGL = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  op;
  logic [IW*NREQ-1:0] idx;
  logic [NREQ-1:0]    gnt;
  logic [NFLAG-1:0]   q;
  logic               conflict;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_conf;

  always #5 clk = ~clk;

  sr_flag_sched #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .op       (op),
    .idx      (idx),
    .gnt      (gnt),
    .q        (q),
    .conflict (conflict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [2:0] ix);
    req[i]        = 1'b1;
    op[2*i +: 2]  = o;
    idx[3*i +: 3] = ix;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    op  = '0;
    idx = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
`ifdef SR_FLAG_SCHED_CONFLICT_EN
    exp_conf = 1'b1;
`else
    exp_conf = 1'b0;
`endif
    rst = 1'b1;
    req = '0;
    op  = '0;
    idx = '0;
    #1 rst = 1'b0;
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q",   32'(q),   32'h0);
    check("rst_conf", 32'(conflict), 32'h0);

    // single request, held one extra cycle to see exclusion
    do_reset();
    set_req(0, SET, 3'd3);
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_q",   32'(q),   32'h08);
    tick();
    check("single_excl_gnt", 32'(gnt), 32'h0);
    check("single_excl_q",   32'(q),   32'h08);
    req = '0;
    tick();
    check("single_idle_gnt", 32'(gnt), 32'h0);

    // full round robin from reset, each requester sets its own flag
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, SET, 3'(i));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      check("rr_q",   32'(q),   (k < 4) ? 32'((1 << (k + 1)) - 1) : 32'h0F);
    end
    check("rr_conf", 32'(conflict), 32'h0);
    req = '0;

    // same-flag set then clear
    do_reset();
    set_req(0, SET, 3'd5);
    set_req(1, CLR, 3'd5);
    tick();
    check("same_gnt0", 32'(gnt), 32'h1);
    check("same_q0",   32'(q),   32'h20);
    check("same_conf0", 32'(conflict), 32'(exp_conf));
    req[0] = 1'b0;
    tick();
    check("same_gnt1", 32'(gnt), 32'h2);
    check("same_q1",   32'(q),   32'h00);
    check("same_conf1", 32'(conflict), 32'h0);
    req = '0;

    // toggle, toggle, nop on flag 7
    do_reset();
    set_req(0, TGL, 3'd7);
    tick();
    check("tgl1_gnt", 32'(gnt), 32'h1);
    check("tgl1_q",   32'(q),   32'h80);
    req = '0;
    tick();
    set_req(0, TGL, 3'd7);
    tick();
    check("tgl2_gnt", 32'(gnt), 32'h1);
    check("tgl2_q",   32'(q),   32'h00);
    req = '0;
    tick();
    set_req(0, NOP, 3'd7);
    tick();
    check("nop_gnt", 32'(gnt), 32'h1);
    check("nop_q",   32'(q),   32'h00);
    req = '0;

    // fill the bank, then reset asynchronously mid-stream
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, SET, 3'(i));
    for (int k = 0; k < 8; k++) begin
      tick();
      check("fill_gnt", 32'(gnt), 32'(1 << (k % 4)));
      check("fill_q",   32'(q),   32'((1 << (k + 1)) - 1));
      idx[3*(k % 4) +: 3] = 3'((k % 4) + 4);
    end
    #2 rst = 1'b0;
    #1;
    check("arst_q",    32'(q),        32'h0);
    check("arst_gnt",  32'(gnt),      32'h0);
    check("arst_conf", 32'(conflict), 32'h0);
    req = '0;
    op  = '0;
    idx = '0;
    set_req(3, SET, 3'd2);
    #2 rst = 1'b1;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h8);
    check("post_rst_q",   32'(q),   32'h04);
    req = '0;
    tick();
    check("post_rst_idle", 32'(gnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
